// File: rtl/rv_decode_stage.sv
// rv_decode_stage: pipelined RV32I decode stage with a two-entry skid buffer.
//
// Accepts one instruction per cycle over a valid/ready handshake and decodes
// it into register indices, a sign-extended immediate, a compact ALU op and
// control flags. Decoding happens before storage, so buffer entries hold
// decoded fields. in_ready depends only on registered state.
//
// Build option: define RV_DECODE_RV32M_EN to decode the M extension
// (OP with funct7=0x01 -> ALU ops 10..17); otherwise those encodings are illegal.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      fetch handshake; in_instr, in_pc, in_tag payload
//   flush                  synchronous kill of all held entries
//   out_valid/out_ready    execute handshake
//   out_pc, out_tag        passed through
//   out_rd/rs1/rs2         register indices, unused fields zeroed
//   out_imm                sign-extended immediate
//   out_fmt                0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 invalid
//   out_alu_op             ALU operation code (31 = none)
//   out_we, out_illegal    rd write enable, unsupported instruction
//
// Buffer states:
//   state | meaning
//   EMPTY | nothing held, out_valid=0
//   ONE   | main entry valid
//   TWO   | main and skid entries valid, in_ready=0
module rv_decode_stage #(
    parameter int PC_W  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_alu_op,
    output logic             out_we,
    output logic             out_illegal
);

    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;
    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_MUL = 5'd10, ALU_PASSB = 5'd18, ALU_NONE = 5'd31;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [TAG_W-1:0] tag;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [31:0]      imm;
        logic [2:0]       fmt;
        logic [4:0]       alu_op;
        logic             we;
        logic             illegal;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, dec;
    logic   load_main_in, load_main_skid, load_skid;
    logic   in_hs, out_hs;

    // funct3 -> ALU op for the shared OP / OP-IMM encodings (shift type resolved separately)
    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'd0:    alu_base = 5'd0;
            3'd1:    alu_base = 5'd2;
            3'd2:    alu_base = 5'd3;
            3'd3:    alu_base = 5'd4;
            3'd4:    alu_base = 5'd5;
            3'd5:    alu_base = 5'd6;
            3'd6:    alu_base = 5'd8;
            default: alu_base = 5'd9;
        endcase
    endfunction

    logic [6:0]  opc, f7;
    logic [2:0]  f3, fmt;
    logic [4:0]  alu;
    logic        ill;
    logic [31:0] imm;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    always_comb begin
        fmt = FMT_X;
        alu = ALU_NONE;
        ill = 1'b0;
        case (opc)
            7'h33: begin
                fmt = FMT_R;
                if (f7 == 7'h00)                     alu = alu_base(f3);
                else if (f7 == 7'h20 && f3 == 3'd0)  alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5)  alu = ALU_SRA;
`ifdef RV_DECODE_RV32M_EN
                else if (f7 == 7'h01)                alu = ALU_MUL + {2'b00, f3};
`endif
                else                                 ill = 1'b1;
            end
            7'h13: begin
                fmt = FMT_I;
                alu = alu_base(f3);
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20)      alu = ALU_SRA;
                    else if (f7 != 7'h00) ill = 1'b1;
                end
            end
            7'h03: begin
                fmt = FMT_I;
                alu = ALU_ADD;
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            7'h23: begin
                fmt = FMT_S;
                alu = ALU_ADD;
                ill = (f3 > 3'd2);
            end
            7'h63: begin
                fmt = FMT_B;
                alu = ALU_SUB;
                ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'h37: begin fmt = FMT_U; alu = ALU_PASSB; end
            7'h17: begin fmt = FMT_U; alu = ALU_ADD; end
            7'h6F: begin fmt = FMT_J; alu = ALU_ADD; end
            7'h67: begin
                fmt = FMT_I;
                alu = ALU_ADD;
                ill = (f3 != 3'd0);
            end
            default: ill = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) ill = 1'b1;

        case (fmt)
            FMT_I:   imm = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm = {in_instr[31:12], 12'b0};
            FMT_J:   imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase

        dec.pc      = in_pc;
        dec.tag     = in_tag;
        dec.rd      = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : in_instr[11:7];
        dec.rs1     = (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : in_instr[19:15];
        dec.rs2     = (fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) ? 5'd0 : in_instr[24:20];
        dec.imm     = imm;
        dec.fmt     = fmt;
        dec.alu_op  = alu;
        dec.we      = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
                      && (in_instr[11:7] != 5'd0);
        dec.illegal = ill;
        // Illegal entries carry no usable decode, only pc/tag and the flag.
        if (ill) begin
            dec.rd     = 5'd0;
            dec.rs1    = 5'd0;
            dec.rs2    = 5'd0;
            dec.imm    = 32'd0;
            dec.fmt    = FMT_X;
            dec.alu_op = ALU_NONE;
            dec.we     = 1'b0;
        end
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_hs) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
                ONE: begin
                    if (in_hs && !out_hs) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (in_hs && out_hs) begin
                        load_main_in = 1'b1;
                    end else if (out_hs) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (out_hs) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in)        main_q <= dec;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= dec;
        end
    end

    assign out_pc      = main_q.pc;
    assign out_tag     = main_q.tag;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_alu_op  = main_q.alu_op;
    assign out_we      = main_q.we;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
module tb_rv_decode_stage;

    localparam int PC_W  = 32;
    localparam int TAG_W = 4;
`ifdef RV_DECODE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam int ALU_TAB[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic [TAG_W-1:0] in_tag;
    logic             flush, out_valid, out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic [31:0]      out_imm;
    logic [2:0]       out_fmt;
    logic [4:0]       out_alu_op;
    logic             out_we, out_illegal;

    int errors = 0;
    int checks = 0;

    rv_decode_stage #(.PC_W(PC_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_tag(out_tag),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_alu_op(out_alu_op),
        .out_we(out_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [TAG_W-1:0] tag;
        logic [4:0]       rd, rs1, rs2;
        logic [31:0]      imm;
        logic [2:0]       fmt;
        logic [4:0]       alu;
        logic             we, ill;
    } exp_t;

    // Reference decode straight from the ISA rules.
    function automatic exp_t model(input logic [31:0] i, input logic [PC_W-1:0] pc,
                                   input logic [TAG_W-1:0] tag);
        exp_t e;
        int fmt, op;
        bit legal;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        f3 = i[14:12];
        f7 = i[31:25];
        legal = (i[1:0] == 2'b11);
        fmt = 7;
        op  = 31;
        case (i[6:0])
            7'h33: begin
                fmt = 0;
                if (f7 == 0) op = ALU_TAB[f3];
                else if (f7 == 7'h20 && f3 == 0) op = 1;
                else if (f7 == 7'h20 && f3 == 5) op = 7;
                else if (M_EN && f7 == 7'h01) op = 10 + int'(f3);
                else legal = 0;
            end
            7'h13: begin
                fmt = 1;
                op  = ALU_TAB[f3];
                if (f3 == 1 && f7 != 0) legal = 0;
                if (f3 == 5 && f7 == 7'h20) op = 7;
                if (f3 == 5 && !(f7 inside {7'h00, 7'h20})) legal = 0;
            end
            7'h03: begin fmt = 1; op = 0; if (f3 inside {3, 6, 7}) legal = 0; end
            7'h23: begin fmt = 2; op = 0; if (f3 > 2) legal = 0; end
            7'h63: begin fmt = 3; op = 1; if (f3 inside {2, 3}) legal = 0; end
            7'h37: begin fmt = 4; op = 18; end
            7'h17: begin fmt = 4; op = 0; end
            7'h6F: begin fmt = 5; op = 0; end
            7'h67: begin fmt = 1; op = 0; if (f3 != 0) legal = 0; end
            default: legal = 0;
        endcase
        e = '0;
        e.pc  = pc;
        e.tag = tag;
        if (!legal) begin
            e.fmt = 3'd7;
            e.alu = 5'd31;
            e.ill = 1'b1;
            return e;
        end
        e.fmt = 3'(fmt);
        e.alu = 5'(op);
        e.rd  = (fmt == 2 || fmt == 3) ? 5'd0 : i[11:7];
        e.rs1 = (fmt == 4 || fmt == 5) ? 5'd0 : i[19:15];
        e.rs2 = (fmt == 0 || fmt == 2 || fmt == 3) ? i[24:20] : 5'd0;
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (fmt)
            1: e.imm = 32'($signed(i) >>> 20);
            2: e.imm = 32'((($signed(i) >>> 25) * 32) + int'(i[11:7]));
            3: e.imm = 32'(int'(b13));
            4: e.imm = i & 32'hFFFFF000;
            5: e.imm = 32'(int'(j21));
            default: e.imm = 32'd0;
        endcase
        e.we = (fmt != 2 && fmt != 3) && (i[11:7] != 0);
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t a;
        a.pc = out_pc; a.tag = out_tag; a.rd = out_rd; a.rs1 = out_rs1; a.rs2 = out_rs2;
        a.imm = out_imm; a.fmt = out_fmt; a.alu = out_alu_op; a.we = out_we; a.ill = out_illegal;
        return a;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops[9];
        int k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) r[6:0] = ops[k];
        if (k < 2) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return r;
    endfunction

    // Offer one instruction with out_ready low, leaving it held in main.
    task automatic send(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        @(negedge clk);
        in_valid = 1'b1; in_instr = instr; in_pc = pc; in_tag = pc[3:0]; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_instr = 0; in_pc = 0; in_tag = 0; flush = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_hs: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        checks++;
        if (observed() !== exp_t'(0)) begin
            errors++; $display("FAIL reset_data: got %h want 0", observed());
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        send(32'h00A00093, 32'h100);
        e = '0; e.pc = 32'h100; e.tag = 4'h0; e.rd = 1; e.imm = 10; e.fmt = 1; e.alu = 0; e.we = 1;
        checks++;
        if (out_valid !== 1'b1 || observed() !== e) begin
            errors++; $display("FAIL addi: valid=%b got %h want %h", out_valid, observed(), e);
        end
        drain();
    endtask

    task automatic test_imm();
        send(32'hFE000EE3, 32'h204);
        checks++;
        if (out_fmt !== 3 || out_alu_op !== 1 || out_imm !== 32'hFFFFFFFC || out_we !== 0 || out_rd !== 0) begin
            errors++; $display("FAIL beq: fmt=%0d alu=%0d imm=%h we=%b rd=%0d want 3 1 fffffffc 0 0",
                               out_fmt, out_alu_op, out_imm, out_we, out_rd);
        end
        drain();
        send(32'h123450B7, 32'h208);
        checks++;
        if (out_imm !== 32'h12345000 || out_alu_op !== 18 || out_fmt !== 4 || out_rd !== 1) begin
            errors++; $display("FAIL lui: imm=%h alu=%0d fmt=%0d rd=%0d want 12345000 18 4 1",
                               out_imm, out_alu_op, out_fmt, out_rd);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] ins[3];
        exp_t held;
        for (int k = 0; k < 3; k++) ins[k] = ((k + 1) << 20) | ((k + 5) << 7) | 32'h13;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = ins[k]; in_pc = 32'h300 + 4 * k; in_tag = 4'(k);
            #1;
            checks++;
            if (in_ready !== (k < 2)) begin
                errors++; $display("FAIL bp_ready%0d: got %b want %b", k, in_ready, k < 2);
            end
            if (k == 2) held = observed();
            @(posedge clk);
        end
        @(negedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || observed() !== held || out_rd !== 5) begin
            errors++; $display("FAIL bp_hold: ready=%b valid=%b rd=%0d want 0 1 5", in_ready, out_valid, out_rd);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 6 || out_imm !== 2 || out_pc !== 32'h304) begin
            errors++; $display("FAIL bp_second: valid=%b rd=%0d imm=%0d pc=%h want 1 6 2 304",
                               out_valid, out_rd, out_imm, out_pc);
        end
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        send(32'h00100293, 32'h400);
        send(32'h00200313, 32'h404);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300393;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_idle%0d: valid=%b want 0", k, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] bad[2];
        bad = '{32'h00000000, 32'h40001033};
        for (int k = 0; k < 2; k++) begin
            send(bad[k], 32'h500 + 4 * k);
            checks++;
            if (out_illegal !== 1 || out_alu_op !== 31 || out_we !== 0 || out_fmt !== 7 || out_imm !== 0) begin
                errors++; $display("FAIL illegal%0d: ill=%b alu=%0d we=%b fmt=%0d imm=%h want 1 31 0 7 0",
                                   k, out_illegal, out_alu_op, out_we, out_fmt, out_imm);
            end
            drain();
        end
    endtask

    task automatic test_m();
        send(32'h02208033, 32'h600);
        checks++;
        if (M_EN) begin
            if (out_illegal !== 0 || out_alu_op !== 10 || out_fmt !== 0 || out_rs1 !== 1 || out_rs2 !== 2) begin
                errors++; $display("FAIL mul: ill=%b alu=%0d fmt=%0d want 0 10 0", out_illegal, out_alu_op, out_fmt);
            end
        end else begin
            if (out_illegal !== 1 || out_alu_op !== 31) begin
                errors++; $display("FAIL mul_off: ill=%b alu=%0d want 1 31", out_illegal, out_alu_op);
            end
        end
        drain();
    endtask

    task automatic test_random();
        exp_t q[$];
        bit ihs, ohs;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            in_tag    = 4'($urandom);
            flush     = ($urandom_range(0, 40) == 0);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_hs c%0d: ready=%b valid=%b want %b %b",
                                   c, in_ready, out_valid, q.size() < 2, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (observed() !== q[0]) begin
                    errors++; $display("FAIL rnd_data c%0d instr: got %h want %h", c, observed(), q[0]);
                end
            end
            ihs = in_valid && (q.size() < 2);
            ohs = out_ready && (q.size() != 0);
            if (flush) q.delete();
            else begin
                if (ohs) void'(q.pop_front());
                if (ihs) q.push_back(model(in_instr, in_pc, in_tag));
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        send(32'h00100293, 32'h700);
        send(32'h00200313, 32'h704);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== exp_t'(0)) begin
            errors++; $display("FAIL reset_mid: valid=%b ready=%b data=%h want 0 1 0", out_valid, in_ready, observed());
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_imm();
        test_backpressure();
        test_flush();
        test_illegal();
        test_m();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
